memory_stage: RTL and testbench

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/mips_pkg.sv | 13 +
 rtl/mem_timeout_counter.sv | 35 +++
 rtl/memory_stage.sv | 147 ++++++++++++++
 tb/tb_memory_stage.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared memory-stage definitions: the access FSM state encoding and
// the default access timeout.
package mips_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int TIMEOUT_CYC_DEFAULT = 16;

endpackage

// File: rtl/mem_timeout_counter.sv
// 8-bit cycle counter for an outstanding data-memory access. terminal is
// raised while the count equals TERMINAL.
module mem_timeout_counter #(
   parameter int TERMINAL = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic terminal
);

   logic [7:0] count_q;
   logic [7:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable) begin
         count_d = count_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign terminal = (count_q == 8'(TERMINAL));

endmodule

// File: rtl/memory_stage.sv
// Pipeline memory stage: issues one load/store per accepted instruction and
// reports the result to writeback. Define MEM_ALIGN_CHECK_EN to reject
// word-misaligned loads/stores without touching memory.
module memory_stage
   import mips_pkg::*;
#(
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT,
   parameter int ADDR_W      = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       ALU_result,
   input  logic [31:0]       write_data,
   input  logic              mem_read,
   input  logic              mem_write,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [31:0]       dmem_wdata,
   input  logic              dmem_ack,
   input  logic [31:0]       dmem_rdata,
   output logic              out_valid,
   output logic [31:0]       out_read_data,
   output logic [31:0]       out_ALU_result,
   output logic              stall,
   output logic              err
);

   state_e      state_q, state_d;
   logic [31:0] alu_q, alu_d;
   logic [31:0] wdata_q, wdata_d;
   logic        we_q, we_d;
   logic        err_q, err_d;
   logic [31:0] rd_q, rd_d;
   logic [31:0] oalu_q, oalu_d;
   logic        cnt_clear;
   logic        cnt_enable;
   logic        cnt_terminal;
   logic        misaligned;

`ifdef MEM_ALIGN_CHECK_EN
   assign misaligned = (mem_read ^ mem_write) && (ALU_result[1:0] != 2'b00);
`else
   assign misaligned = 1'b0;
`endif

   mem_timeout_counter #(
      .TERMINAL (TIMEOUT_CYC - 1)
   ) u_timeout (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (cnt_clear),
      .enable   (cnt_enable),
      .terminal (cnt_terminal)
   );

   // Result registers only change on entry to DONE, so writeback sees them
   // held until the next out_valid.
   always_comb begin
      state_d    = state_q;
      alu_d      = alu_q;
      wdata_d    = wdata_q;
      we_d       = we_q;
      err_d      = err_q;
      rd_d       = rd_q;
      oalu_d     = oalu_q;
      cnt_clear  = 1'b0;
      cnt_enable = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               alu_d   = ALU_result;
               wdata_d = write_data;
               we_d    = mem_write;
               err_d   = 1'b0;
               if ((mem_read && mem_write) || misaligned) begin
                  state_d = DONE;
                  err_d   = 1'b1;
                  rd_d    = '0;
                  oalu_d  = ALU_result;
               end else if (mem_read || mem_write) begin
                  state_d   = REQ;
                  cnt_clear = 1'b1;
               end else begin
                  state_d = DONE;
                  rd_d    = '0;
                  oalu_d  = ALU_result;
               end
            end
         end
         REQ: begin
            cnt_enable = !dmem_ack;
            if (dmem_ack) begin
               state_d = DONE;
               rd_d    = we_q ? 32'd0 : dmem_rdata;
               oalu_d  = alu_q;
               err_d   = 1'b0;
            end else if (cnt_terminal) begin
               state_d = DONE;
               rd_d    = '0;
               oalu_d  = alu_q;
               err_d   = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         alu_q   <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         rd_q    <= '0;
         oalu_q  <= '0;
      end else begin
         state_q <= state_d;
         alu_q   <= alu_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         err_q   <= err_d;
         rd_q    <= rd_d;
         oalu_q  <= oalu_d;
      end
   end

   assign in_ready       = (state_q == IDLE);
   assign stall          = (state_q != IDLE);
   assign dmem_req       = (state_q == REQ);
   assign dmem_we        = dmem_req && we_q;
   assign dmem_addr      = alu_q[ADDR_W-1:0];
   assign dmem_wdata     = wdata_q;
   assign out_valid      = (state_q == DONE);
   assign err            = out_valid && err_q;
   assign out_read_data  = rd_q;
   assign out_ALU_result = oalu_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage with a 4-cycle timeout; expectations are
// hand-computed per vector.
module tb_memory_stage;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] ALU_result;
   logic [31:0] write_data;
   logic        mem_read;
   logic        mem_write;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic        out_valid;
   logic [31:0] out_read_data;
   logic [31:0] out_ALU_result;
   logic        stall;
   logic        err;

   int checks = 0;
   int errors = 0;

   memory_stage #(
      .TIMEOUT_CYC (4),
      .ADDR_W      (32)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .ALU_result     (ALU_result),
      .write_data     (write_data),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .dmem_req       (dmem_req),
      .dmem_we        (dmem_we),
      .dmem_addr      (dmem_addr),
      .dmem_wdata     (dmem_wdata),
      .dmem_ack       (dmem_ack),
      .dmem_rdata     (dmem_rdata),
      .out_valid      (out_valid),
      .out_read_data  (out_read_data),
      .out_ALU_result (out_ALU_result),
      .stall          (stall),
      .err            (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Present one instruction for exactly one rising edge (stage must be idle).
   task automatic applyStimulus(input logic [31:0] alu, input logic [31:0] wd,
                                input logic rd, input logic wr);
      in_valid   = 1'b1;
      ALU_result = alu;
      write_data = wd;
      mem_read   = rd;
      mem_write  = wr;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int reqCycles;
      logic sawValid;

      rst_n      = 1'b0;
      in_valid   = 1'b0;
      ALU_result = '0;
      write_data = '0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      dmem_ack   = 1'b0;
      dmem_rdata = '0;

      #3;
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_err", 32'(err), 32'd0);
      checkOutput("rst_dmem_req", 32'(dmem_req), 32'd0);
      checkOutput("rst_dmem_addr", dmem_addr, 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("rst_out_rd", out_read_data, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] no-access pass-through");
      applyStimulus(32'h0000_002A, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("na_out_valid", 32'(out_valid), 32'd1);
      checkOutput("na_out_alu", out_ALU_result, 32'h0000_002A);
      checkOutput("na_out_rd", out_read_data, 32'd0);
      checkOutput("na_dmem_req", 32'(dmem_req), 32'd0);
      checkOutput("na_err", 32'(err), 32'd0);
      @(negedge clk);
      checkOutput("na_valid_drop", 32'(out_valid), 32'd0);
      checkOutput("na_alu_hold", out_ALU_result, 32'h0000_002A);

      $display("[TB] load with ack on third request cycle");
      applyStimulus(32'h0000_0100, 32'h0, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("ld_req_c1", 32'(dmem_req), 32'd1);
      checkOutput("ld_addr_c1", dmem_addr, 32'h0000_0100);
      checkOutput("ld_we_c1", 32'(dmem_we), 32'd0);
      checkOutput("ld_in_ready_c1", 32'(in_ready), 32'd0);
      @(negedge clk);
      checkOutput("ld_req_c2", 32'(dmem_req), 32'd1);
      checkOutput("ld_addr_c2", dmem_addr, 32'h0000_0100);
      @(negedge clk);
      checkOutput("ld_req_c3", 32'(dmem_req), 32'd1);
      checkOutput("ld_in_ready_c3", 32'(in_ready), 32'd0);
      dmem_ack   = 1'b1;
      dmem_rdata = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      dmem_ack = 1'b0;
      @(negedge clk);
      checkOutput("ld_out_valid", 32'(out_valid), 32'd1);
      checkOutput("ld_out_rd", out_read_data, 32'hDEAD_BEEF);
      checkOutput("ld_out_alu", out_ALU_result, 32'h0000_0100);
      checkOutput("ld_req_drop", 32'(dmem_req), 32'd0);
      checkOutput("ld_in_ready_done", 32'(in_ready), 32'd0);
      checkOutput("ld_err", 32'(err), 32'd0);
      @(negedge clk);
      checkOutput("ld_valid_drop", 32'(out_valid), 32'd0);
      checkOutput("ld_rd_hold", out_read_data, 32'hDEAD_BEEF);

      $display("[TB] store with immediate ack");
      applyStimulus(32'h0000_0104, 32'h1234_5678, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("st_req", 32'(dmem_req), 32'd1);
      checkOutput("st_we", 32'(dmem_we), 32'd1);
      checkOutput("st_addr", dmem_addr, 32'h0000_0104);
      checkOutput("st_wdata", dmem_wdata, 32'h1234_5678);
      dmem_ack   = 1'b1;
      dmem_rdata = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      dmem_ack = 1'b0;
      @(negedge clk);
      checkOutput("st_out_valid", 32'(out_valid), 32'd1);
      checkOutput("st_out_rd", out_read_data, 32'd0);
      checkOutput("st_err", 32'(err), 32'd0);
      @(negedge clk);

      $display("[TB] load timeout without ack");
      applyStimulus(32'h0000_0200, 32'h0, 1'b1, 1'b0);
      reqCycles = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (dmem_req) reqCycles++;
         if (out_valid) break;
      end
      checkOutput("to_req_cycles", 32'(reqCycles), 32'd4);
      checkOutput("to_out_valid", 32'(out_valid), 32'd1);
      checkOutput("to_err", 32'(err), 32'd1);
      checkOutput("to_out_rd", out_read_data, 32'd0);
      @(negedge clk);
      checkOutput("to_err_drop", 32'(err), 32'd0);

      $display("[TB] ack on the terminal cycle");
      applyStimulus(32'h0000_0300, 32'h0, 1'b1, 1'b0);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      checkOutput("ta_req_c4", 32'(dmem_req), 32'd1);
      dmem_ack   = 1'b1;
      dmem_rdata = 32'hCAFE_F00D;
      @(posedge clk);
      #1;
      dmem_ack = 1'b0;
      @(negedge clk);
      checkOutput("ta_out_valid", 32'(out_valid), 32'd1);
      checkOutput("ta_err", 32'(err), 32'd0);
      checkOutput("ta_out_rd", out_read_data, 32'hCAFE_F00D);
      @(negedge clk);

      $display("[TB] read and write both set");
      applyStimulus(32'h0000_0040, 32'h5555_AAAA, 1'b1, 1'b1);
      @(negedge clk);
      checkOutput("rw_out_valid", 32'(out_valid), 32'd1);
      checkOutput("rw_err", 32'(err), 32'd1);
      checkOutput("rw_dmem_req", 32'(dmem_req), 32'd0);
      checkOutput("rw_out_rd", out_read_data, 32'd0);
      @(negedge clk);
      checkOutput("rw_valid_drop", 32'(out_valid), 32'd0);

      $display("[TB] ack while idle");
      dmem_ack   = 1'b1;
      dmem_rdata = 32'h0BAD_0BAD;
      @(negedge clk);
      dmem_ack = 1'b0;
      checkOutput("ia_out_valid", 32'(out_valid), 32'd0);
      checkOutput("ia_stall", 32'(stall), 32'd0);
      @(negedge clk);
      checkOutput("ia_out_valid2", 32'(out_valid), 32'd0);

      $display("[TB] reset during request");
      applyStimulus(32'h0000_0500, 32'h0, 1'b1, 1'b0);
      @(negedge clk);
      @(negedge clk);
      checkOutput("rr_req_before", 32'(dmem_req), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("rr_req_now", 32'(dmem_req), 32'd0);
      checkOutput("rr_in_ready", 32'(in_ready), 32'd1);
      checkOutput("rr_addr", dmem_addr, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      sawValid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (out_valid || err) sawValid = 1'b1;
      end
      checkOutput("rr_no_valid", 32'(sawValid), 32'd0);
      applyStimulus(32'h0000_0600, 32'h0, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("rr_next_req", 32'(dmem_req), 32'd1);
      dmem_ack   = 1'b1;
      dmem_rdata = 32'h1111_2222;
      @(posedge clk);
      #1;
      dmem_ack = 1'b0;
      @(negedge clk);
      checkOutput("rr_next_valid", 32'(out_valid), 32'd1);
      checkOutput("rr_next_rd", out_read_data, 32'h1111_2222);
      @(negedge clk);

      $display("[TB] misaligned load at 0x102");
      applyStimulus(32'h0000_0102, 32'h0, 1'b1, 1'b0);
      @(negedge clk);
`ifdef MEM_ALIGN_CHECK_EN
      checkOutput("al_out_valid", 32'(out_valid), 32'd1);
      checkOutput("al_err", 32'(err), 32'd1);
      checkOutput("al_dmem_req", 32'(dmem_req), 32'd0);
      checkOutput("al_out_rd", out_read_data, 32'd0);
`else
      checkOutput("al_dmem_req", 32'(dmem_req), 32'd1);
      checkOutput("al_addr", dmem_addr, 32'h0000_0102);
      dmem_ack   = 1'b1;
      dmem_rdata = 32'h7777_8888;
      @(posedge clk);
      #1;
      dmem_ack = 1'b0;
      @(negedge clk);
      checkOutput("al_out_valid", 32'(out_valid), 32'd1);
      checkOutput("al_out_rd", out_read_data, 32'h7777_8888);
`endif
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
